// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
//   Shared declarations for the async SRAM controller.
//   - sram_state_t : controller FSM states
//   - WAIT_CNT_W   : width of the wait-state counter
//   - lane_count() : number of byte lanes for a given data width
// ---------------------------------------------------------------------------
package sram_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_R_ACCESS,
        ST_W_SETUP,
        ST_W_PULSE,
        ST_W_HOLD,
        ST_DONE
    } sram_state_t;

    function automatic int lane_count(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/byte_lane_swap.sv
// ---------------------------------------------------------------------------
// byte_lane_swap
//   Pure combinational lane reversal. Lane i of i_data appears on lane
//   NL-1-i of o_data when BYTE_SWAP != 0, otherwise a straight pass-through.
//   LANE_W = 8 reorders data bytes; LANE_W = 1 reorders per-byte enables.
// Ports
//   i_data  in   DATA_W   input word
//   o_data  out  DATA_W   lane-reordered word
// ---------------------------------------------------------------------------
module byte_lane_swap #(
    parameter int DATA_W    = 32,
    parameter int LANE_W    = 8,
    parameter int BYTE_SWAP = 1
) (
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    localparam int NL = DATA_W / LANE_W;

    always_comb begin
        o_data = i_data;
        if (BYTE_SWAP != 0) begin
            for (int unsigned i = 0; i < NL; i++) begin
                o_data[i*LANE_W +: LANE_W] = i_data[(NL-1-i)*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
//   Converts single-word req/ack transactions into timed async SRAM cycles
//   with programmable wait states, byte-lane enables and optional lane swap.
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req, we           request / write select (sampled in IDLE only)
//   addr, be, wdata   word address, byte enables, write data (CPU lane order)
//   rdata, ack, busy  read data (held until next read), completion pulse, busy
//   ram_addr          registered SRAM address
//   ram_be_n          SRAM byte enables, active-low, SRAM lane order
//   ram_ce_n/oe_n/we_n SRAM strobes, active-low
//   ram_data          bidirectional SRAM data bus
// ---------------------------------------------------------------------------
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1,
    parameter int BYTE_SWAP   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ack,
    output logic                  busy,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W/8-1:0]   ram_be_n,
    output logic                  ram_ce_n,
    output logic                  ram_oe_n,
    output logic                  ram_we_n,
    inout  wire  [DATA_W-1:0]     ram_data
);

    localparam int NB = lane_count(DATA_W);
    localparam logic [WAIT_CNT_W-1:0] LP_WAIT = WAIT_CNT_W'(WAIT_CYCLES);

    sram_state_t             r_state;
    logic [WAIT_CNT_W-1:0]   r_wait;
    logic [ADDR_W-1:0]       r_addr;
    logic [NB-1:0]           r_be_s;
    logic [DATA_W-1:0]       r_wdata_s;
    logic [DATA_W-1:0]       r_rdata;
    logic [NB-1:0]           r_be_n;
    logic                    r_drive;
    logic                    r_ce_n;
    logic                    r_oe_n;
    logic                    r_we_n;
    logic                    r_ack;
    logic                    r_busy;

    logic [DATA_W-1:0]       w_wdata_s;
    logic [NB-1:0]           w_be_s;
    logic [DATA_W-1:0]       w_rdata_cpu;

    byte_lane_swap #(.DATA_W(DATA_W), .LANE_W(8), .BYTE_SWAP(BYTE_SWAP)) u_swap_wdata (
        .i_data (wdata),
        .o_data (w_wdata_s)
    );

    byte_lane_swap #(.DATA_W(NB), .LANE_W(1), .BYTE_SWAP(BYTE_SWAP)) u_swap_be (
        .i_data (be),
        .o_data (w_be_s)
    );

    byte_lane_swap #(.DATA_W(DATA_W), .LANE_W(8), .BYTE_SWAP(BYTE_SWAP)) u_swap_rdata (
        .i_data (ram_data),
        .o_data (w_rdata_cpu)
    );

    // Pins are registered alongside the state: every transition loads the
    // strobe values that belong to the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_wait    <= '0;
            r_addr    <= '0;
            r_be_s    <= '0;
            r_wdata_s <= '0;
            r_rdata   <= '0;
            r_be_n    <= '1;
            r_drive   <= 1'b0;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_addr    <= addr;
                        r_be_s    <= w_be_s;
                        r_wdata_s <= w_wdata_s;
                        r_be_n    <= ~w_be_s;
                        r_ce_n    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_wait    <= LP_WAIT;
                        if (we) begin
                            r_state <= ST_W_SETUP;
                            r_drive <= 1'b1;
                        end else begin
                            r_state <= ST_R_ACCESS;
                            r_oe_n  <= 1'b0;
                        end
                    end
                end
                ST_R_ACCESS: begin
                    if (r_wait == '0) begin
                        r_rdata <= w_rdata_cpu;
                        r_state <= ST_DONE;
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_be_n  <= '1;
                        r_ack   <= 1'b1;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                ST_W_SETUP: begin
                    r_state <= ST_W_PULSE;
                    r_wait  <= LP_WAIT;
                    // No enabled lanes: keep WE high so the cycle is a no-op.
                    r_we_n  <= (r_be_s == '0);
                end
                ST_W_PULSE: begin
                    if (r_wait == '0) begin
                        r_state <= ST_W_HOLD;
                        r_we_n  <= 1'b1;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                ST_W_HOLD: begin
                    r_state <= ST_DONE;
                    r_drive <= 1'b0;
                    r_ce_n  <= 1'b1;
                    r_be_n  <= '1;
                    r_ack   <= 1'b1;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram_data = r_drive ? r_wdata_s : 'z;

    assign rdata    = r_rdata;
    assign ack      = r_ack;
    assign busy     = r_busy;
    assign ram_addr = r_addr;
    assign ram_be_n = r_be_n;
    assign ram_ce_n = r_ce_n;
    assign ram_oe_n = r_oe_n;
    assign ram_we_n = r_we_n;

endmodule

// File: tb/tb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_ctrl
//   Two controller instances, each with a behavioural SRAM:
//   u_dut1 (WAIT_CYCLES=1) for reset/write/read cases, u_dut0 (WAIT_CYCLES=0)
//   for back-to-back traffic. Expected results are queued at issue time and
//   popped when ack arrives.
// ---------------------------------------------------------------------------
module tb_sram_ctrl;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int NB = 4;

    typedef struct {
        bit          rd;
        logic [31:0] data;
        int          lat;
    } sb_t;

    sb_t sb[$];

    int tests  = 0;
    int failed = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           we;
    logic [AW-1:0]  addr;
    logic [NB-1:0]  be;
    logic [DW-1:0]  wdata;
    logic           req1, req0;

    logic [DW-1:0]  rdata1, rdata0;
    logic           ack1, ack0, busy1, busy0;
    logic [AW-1:0]  ra1, ra0;
    logic [NB-1:0]  rbe1, rbe0;
    logic           ce1, oe1, we1, ce0, oe0, we0;
    wire  [DW-1:0]  bus1, bus0;

    logic [31:0] mem1 [0:255];
    logic [31:0] mem0 [0:255];

    int nwe1 = 0;
    int noe1 = 0;
    int viol = 0;

    sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1), .BYTE_SWAP(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req1), .we(we), .addr(addr), .be(be), .wdata(wdata),
        .rdata(rdata1), .ack(ack1), .busy(busy1), .ram_addr(ra1), .ram_be_n(rbe1),
        .ram_ce_n(ce1), .ram_oe_n(oe1), .ram_we_n(we1), .ram_data(bus1)
    );

    sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0), .BYTE_SWAP(1)) u_dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .be(be), .wdata(wdata),
        .rdata(rdata0), .ack(ack0), .busy(busy0), .ram_addr(ra0), .ram_be_n(rbe0),
        .ram_ce_n(ce0), .ram_oe_n(oe0), .ram_we_n(we0), .ram_data(bus0)
    );

    // Behavioural SRAMs: per-lane write while CE and WE are low, read drive while CE and OE low
    always @(posedge clk) begin
        if (!ce1 && !we1)
            for (int i = 0; i < NB; i++)
                if (!rbe1[i]) mem1[ra1[7:0]][i*8 +: 8] <= bus1[i*8 +: 8];
        if (!ce0 && !we0)
            for (int i = 0; i < NB; i++)
                if (!rbe0[i]) mem0[ra0[7:0]][i*8 +: 8] <= bus0[i*8 +: 8];
    end

    assign bus1 = (!ce1 && !oe1) ? mem1[ra1[7:0]] : 'z;
    assign bus0 = (!ce0 && !oe0) ? mem0[ra0[7:0]] : 'z;

    // Strobe monitors; a controller driving during OE would corrupt the read value
    always @(negedge clk) begin
        if (!we1) nwe1++;
        if (!oe1) noe1++;
        if (!oe1 && !we1) viol++;
        if (!oe0 && !we0) viol++;
        if (!ce0 && !oe0 && (bus0 !== mem0[ra0[7:0]])) viol++;
    end

    function automatic logic [31:0] swap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Present one request in the current cycle; return at the ack cycle with req dropped
    task automatic issue(input bit s, input bit w, input logic [AW-1:0] a, input logic [NB-1:0] b,
                         input logic [DW-1:0] d, output int lat, output logic [31:0] rd, output bit got);
        we = w; addr = a; be = b; wdata = d;
        if (s) req0 = 1'b1; else req1 = 1'b1;
        got = 1'b0; lat = 0; rd = '0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(posedge clk); #1;
            if (s ? ack0 : ack1) begin
                got = 1'b1; lat = c; rd = s ? rdata0 : rdata1;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        tests++; if (ce1 !== 1'b1)  begin failed++; $display("FAIL rst_ce_n: got %b expected 1", ce1); end
        tests++; if (oe1 !== 1'b1)  begin failed++; $display("FAIL rst_oe_n: got %b expected 1", oe1); end
        tests++; if (we1 !== 1'b1)  begin failed++; $display("FAIL rst_we_n: got %b expected 1", we1); end
        tests++; if (rbe1 !== 4'hF) begin failed++; $display("FAIL rst_be_n: got %h expected f", rbe1); end
        tests++; if (ra1 !== '0)    begin failed++; $display("FAIL rst_addr: got %h expected 0", ra1); end
        tests++; if (rdata1 !== '0) begin failed++; $display("FAIL rst_rdata: got %h expected 0", rdata1); end
        tests++; if (ack1 !== 1'b0) begin failed++; $display("FAIL rst_ack: got %b expected 0", ack1); end
        tests++; if (busy1 !== 1'b0) begin failed++; $display("FAIL rst_busy: got %b expected 0", busy1); end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] old;
        old = mem1[8'h20];
        we = 1'b1; addr = 20'h00020; be = 4'hF; wdata = 32'hDEADBEEF; req1 = 1'b1;
        next_cycle();
        tests++; if (ce1 !== 1'b0) begin failed++; $display("FAIL midrst_accept: ce_n got %b expected 0", ce1); end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            tests++; if (ack1 !== 1'b0) begin failed++; $display("FAIL midrst_ack: got %b expected 0", ack1); end
            tests++; if ({ce1, we1, busy1} !== 3'b110)
                begin failed++; $display("FAIL midrst_pins: ce_n,we_n,busy got %b expected 110", {ce1, we1, busy1}); end
        end
        rst = 1'b0; req1 = 1'b0;
        next_cycle();
        tests++; if (mem1[8'h20] !== old)
            begin failed++; $display("FAIL midrst_sram: got %h expected %h", mem1[8'h20], old); end
        tests++; if (ack1 !== 1'b0) begin failed++; $display("FAIL midrst_noack: got %b expected 0", ack1); end
    endtask

    task automatic test_write_full();
        int lat; logic [31:0] rd; bit got; sb_t e;
        nwe1 = 0;
        sb.push_back('{rd: 1'b0, data: 32'h44332211, lat: 5});
        issue(1'b0, 1'b1, 20'h00010, 4'hF, 32'h11223344, lat, rd, got);
        e = sb.pop_front();
        tests++; if (!got || lat != e.lat) begin failed++; $display("FAIL wfull_latency: got %0d expected %0d", lat, e.lat); end
        tests++; if (mem1[8'h10] !== e.data) begin failed++; $display("FAIL wfull_sram: got %h expected %h", mem1[8'h10], e.data); end
        tests++; if (nwe1 != 2) begin failed++; $display("FAIL wfull_we_cycles: got %0d expected 2", nwe1); end
        next_cycle();
        tests++; if ({ack1, busy1} !== 2'b00) begin failed++; $display("FAIL wfull_ack_pulse: ack,busy got %b expected 00", {ack1, busy1}); end
    endtask

    task automatic test_write_partial();
        int lat; logic [31:0] rd; bit got; sb_t e;
        sb.push_back('{rd: 1'b0, data: 32'hAA332211, lat: 5});
        issue(1'b0, 1'b1, 20'h00010, 4'b0001, 32'h000000AA, lat, rd, got);
        e = sb.pop_front();
        tests++; if (!got || lat != e.lat) begin failed++; $display("FAIL wpart_latency: got %0d expected %0d", lat, e.lat); end
        tests++; if (mem1[8'h10] !== e.data) begin failed++; $display("FAIL wpart_sram: got %h expected %h", mem1[8'h10], e.data); end
        next_cycle();
    endtask

    task automatic test_read();
        int lat; logic [31:0] rd; bit got; sb_t e;
        noe1 = 0;
        sb.push_back('{rd: 1'b1, data: 32'h112233AA, lat: 3});
        issue(1'b0, 1'b0, 20'h00010, 4'hF, 32'h0, lat, rd, got);
        e = sb.pop_front();
        tests++; if (!got || lat != e.lat) begin failed++; $display("FAIL read_latency: got %0d expected %0d", lat, e.lat); end
        tests++; if (rd !== e.data) begin failed++; $display("FAIL read_data: got %h expected %h", rd, e.data); end
        tests++; if (noe1 != 2) begin failed++; $display("FAIL read_oe_cycles: got %0d expected 2", noe1); end
        next_cycle();
    endtask

    task automatic test_write_be0();
        int lat; logic [31:0] rd; bit got; sb_t e;
        nwe1 = 0;
        sb.push_back('{rd: 1'b0, data: 32'hAA332211, lat: 5});
        issue(1'b0, 1'b1, 20'h00010, 4'b0000, 32'hFFFFFFFF, lat, rd, got);
        e = sb.pop_front();
        tests++; if (!got || lat != e.lat) begin failed++; $display("FAIL wbe0_latency: got %0d expected %0d", lat, e.lat); end
        tests++; if (nwe1 != 0) begin failed++; $display("FAIL wbe0_we_cycles: got %0d expected 0", nwe1); end
        tests++; if (mem1[8'h10] !== e.data) begin failed++; $display("FAIL wbe0_sram: got %h expected %h", mem1[8'h10], e.data); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; bit got; sb_t e; logic [31:0] first;
        viol = 0;
        first = swap32(mem0[8'h05]);
        sb.push_back('{rd: 1'b1, data: first, lat: 2});
        sb.push_back('{rd: 1'b0, data: 32'h0DF0FECA, lat: 4});
        sb.push_back('{rd: 1'b1, data: 32'hCAFEF00D, lat: 2});

        issue(1'b1, 1'b0, 20'h00005, 4'hF, 32'h0, lat, rd, got);
        e = sb.pop_front();
        tests++; if (!got || lat != e.lat) begin failed++; $display("FAIL b2b_rd1_latency: got %0d expected %0d", lat, e.lat); end
        tests++; if (rd !== e.data) begin failed++; $display("FAIL b2b_rd1_data: got %h expected %h", rd, e.data); end
        tests++; if (busy0 !== 1'b1) begin failed++; $display("FAIL b2b_busy_ack_cycle: got %b expected 1", busy0); end
        next_cycle();

        issue(1'b1, 1'b1, 20'h00005, 4'hF, 32'hCAFEF00D, lat, rd, got);
        e = sb.pop_front();
        tests++; if (!got || lat != e.lat) begin failed++; $display("FAIL b2b_wr_latency: got %0d expected %0d", lat, e.lat); end
        tests++; if (mem0[8'h05] !== e.data) begin failed++; $display("FAIL b2b_wr_sram: got %h expected %h", mem0[8'h05], e.data); end
        tests++; if (rdata0 !== first) begin failed++; $display("FAIL b2b_rdata_hold: got %h expected %h", rdata0, first); end
        next_cycle();

        issue(1'b1, 1'b0, 20'h00005, 4'hF, 32'h0, lat, rd, got);
        e = sb.pop_front();
        tests++; if (!got || lat != e.lat) begin failed++; $display("FAIL b2b_rd2_latency: got %0d expected %0d", lat, e.lat); end
        tests++; if (rd !== e.data) begin failed++; $display("FAIL b2b_rd2_data: got %h expected %h", rd, e.data); end
        next_cycle();
        tests++; if (viol != 0) begin failed++; $display("FAIL bus_protocol: got %0d violations expected 0", viol); end
    endtask

    initial begin
        rst = 1'b1; req1 = 1'b0; req0 = 1'b0;
        we = 1'b0; addr = '0; be = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        next_cycle();
        test_reset_mid_write();
        test_write_full();
        test_write_partial();
        test_read();
        test_write_be0();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
